// File: rtl/branch_redirect_buffer.sv
// Branch redirect buffer: keeps the oldest outstanding mispredict redirect
// and offers it to the frontend over a valid/ready handshake. After a redirect
// fires, younger mispredicts are squashed until the backend flush completes.
module branch_redirect_buffer #(
    parameter int ROB_WIDTH  = 5,
    parameter int FSQ_WIDTH  = 4,
    parameter int VADDR_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_en,
    input  logic [ROB_WIDTH:0]    in_rob_idx,
    input  logic [FSQ_WIDTH-1:0]  in_fsq_idx,
    input  logic [VADDR_SIZE-1:0] in_target,
    input  logic                  in_taken,
    input  logic [1:0]            in_br_type,
    input  logic [1:0]            in_ras_type,
    input  logic                  rob_flush,
    input  logic                  flush_done,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ROB_WIDTH:0]    out_rob_idx,
    output logic [FSQ_WIDTH-1:0]  out_fsq_idx,
    output logic [VADDR_SIZE-1:0] out_target,
    output logic                  out_taken,
    output logic [1:0]            out_br_type,
    output logic [1:0]            out_ras_type,
    output logic                  busy,
    output logic [31:0]           redirect_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e                  state_q, state_d;
    logic                    valid_q, busy_q;
    logic                    load_s, fire_s;
    logic [ROB_WIDTH:0]      last_q, last_d;
    logic [ROB_WIDTH:0]      rob_q;
    logic [FSQ_WIDTH-1:0]    fsq_q;
    logic [VADDR_SIZE-1:0]   target_q;
    logic                    taken_q;
    logic [1:0]              br_type_q, ras_type_q;
    logic [31:0]             cnt_q;

    // ROB age compare with wrap flag: same flag compares index directly,
    // differing flags mean the larger index was allocated before the wrap.
    function automatic logic is_older(input logic [ROB_WIDTH:0] a,
                                      input logic [ROB_WIDTH:0] b);
        logic older;
        if (a[ROB_WIDTH] == b[ROB_WIDTH]) begin
            older = (a[ROB_WIDTH-1:0] < b[ROB_WIDTH-1:0]);
        end else begin
            older = (a[ROB_WIDTH-1:0] > b[ROB_WIDTH-1:0]);
        end
        return older;
    endfunction

    // valid_q is high exactly while in PEND, so this is the handshake.
    assign fire_s = valid_q & out_ready;

    // Next-state, payload-load and last-fired-id selection.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        if (fire_s) begin
            last_d = rob_q;
        end else begin
            last_d = last_q;
        end
        if (rob_flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_en) begin
                        load_s  = 1'b1;
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PEND: begin
                    if (in_en && is_older(in_rob_idx, rob_q)) begin
                        load_s  = 1'b1;
                        state_d = ST_PEND;
                    end else if (fire_s) begin
                        state_d = ST_WAIT;
                    end else begin
                        state_d = ST_PEND;
                    end
                end
                ST_WAIT: begin
                    if (flush_done) begin
                        if (in_en) begin
                            load_s  = 1'b1;
                            state_d = ST_PEND;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else if (in_en && is_older(in_rob_idx, last_q)) begin
                        load_s  = 1'b1;
                        state_d = ST_PEND;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Control flops; valid/busy are registered so no output has a comb path.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d == ST_PEND);
            busy_q  <= (state_d != ST_IDLE);
            last_q  <= last_d;
        end
    end

    // Payload register, loaded as a whole on an accepted redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rob_q      <= '0;
            fsq_q      <= '0;
            target_q   <= '0;
            taken_q    <= 1'b0;
            br_type_q  <= 2'b00;
            ras_type_q <= 2'b00;
        end else if (load_s) begin
            rob_q      <= in_rob_idx;
            fsq_q      <= in_fsq_idx;
            target_q   <= in_target;
            taken_q    <= in_taken;
            br_type_q  <= in_br_type;
            ras_type_q <= in_ras_type;
        end else begin
            rob_q      <= rob_q;
            fsq_q      <= fsq_q;
            target_q   <= target_q;
            taken_q    <= taken_q;
            br_type_q  <= br_type_q;
            ras_type_q <= ras_type_q;
        end
    end

    // Saturating count of fired redirects (a fire alongside rob_flush counts).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 32'd0;
        end else if (fire_s && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_q <= cnt_q + 32'd1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign out_valid    = valid_q;
    assign busy         = busy_q;
    assign out_rob_idx  = rob_q;
    assign out_fsq_idx  = fsq_q;
    assign out_target   = target_q;
    assign out_taken    = taken_q;
    assign out_br_type  = br_type_q;
    assign out_ras_type = ras_type_q;
    assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_branch_redirect_buffer.sv
// Bench for branch_redirect_buffer: directed scenarios plus a randomized run
// against a behavioural model that tracks "pending" and "squash window" flags.
module tb_branch_redirect_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_en;
    logic [5:0]  in_rob_idx;
    logic [3:0]  in_fsq_idx;
    logic [31:0] in_target;
    logic        in_taken;
    logic [1:0]  in_br_type, in_ras_type;
    logic        rob_flush, flush_done, out_ready;
    logic        out_valid, out_taken, busy;
    logic [5:0]  out_rob_idx;
    logic [3:0]  out_fsq_idx;
    logic [31:0] out_target, redirect_cnt;
    logic [1:0]  out_br_type, out_ras_type;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    bit          m_pend, m_wait;
    logic [5:0]  m_rob, m_last;
    logic [3:0]  m_fsq;
    logic [31:0] m_tgt, m_cnt;
    logic        m_tk;
    logic [1:0]  m_bt, m_rt;

    always #5 clk = ~clk;

    branch_redirect_buffer #(.ROB_WIDTH(5), .FSQ_WIDTH(4), .VADDR_SIZE(32)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .in_rob_idx(in_rob_idx),
        .in_fsq_idx(in_fsq_idx), .in_target(in_target), .in_taken(in_taken),
        .in_br_type(in_br_type), .in_ras_type(in_ras_type),
        .rob_flush(rob_flush), .flush_done(flush_done),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rob_idx(out_rob_idx), .out_fsq_idx(out_fsq_idx),
        .out_target(out_target), .out_taken(out_taken),
        .out_br_type(out_br_type), .out_ras_type(out_ras_type),
        .busy(busy), .redirect_cnt(redirect_cnt)
    );

    // a older than b: distance a-b modulo 64 lands in the upper half (excl. 32)
    function automatic bit m_older(input logic [5:0] a, input logic [5:0] b);
        int d;
        d = (int'(a) - int'(b) + 64) % 64;
        return d > 32;
    endfunction

    task automatic model_reset();
        m_pend = 1'b0; m_wait = 1'b0; m_rob = 6'd0; m_last = 6'd0;
        m_fsq = 4'd0; m_tgt = 32'd0; m_tk = 1'b0; m_bt = 2'd0; m_rt = 2'd0;
        m_cnt = 32'd0;
    endtask

    task automatic model_step(input bit en, input logic [5:0] rob, input logic [3:0] fsq,
                              input logic [31:0] tgt, input bit tk, input logic [1:0] bt,
                              input logic [1:0] rt, input bit rdy, input bit rf, input bit fd);
        bit fire, take;
        fire = m_pend && rdy;
        take = 1'b0;
        if (fire) begin
            if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            m_last = m_rob;
        end
        if (rf) begin
            m_pend = 1'b0; m_wait = 1'b0;
        end else if (m_pend) begin
            if (en && m_older(rob, m_rob)) take = 1'b1;
            else if (fire) begin m_pend = 1'b0; m_wait = 1'b1; end
        end else if (m_wait) begin
            if (fd) begin m_wait = 1'b0; take = en; end
            else take = en && m_older(rob, m_last);
        end else begin
            take = en;
        end
        if (take) begin
            m_pend = 1'b1; m_wait = 1'b0;
            m_rob = rob; m_fsq = fsq; m_tgt = tgt; m_tk = tk; m_bt = bt; m_rt = rt;
        end
    endtask

    task automatic cycle(input bit en, input logic [5:0] rob, input logic [3:0] fsq,
                         input logic [31:0] tgt, input bit tk, input logic [1:0] bt,
                         input logic [1:0] rt, input bit rdy, input bit rf, input bit fd);
        in_en = en; in_rob_idx = rob; in_fsq_idx = fsq; in_target = tgt;
        in_taken = tk; in_br_type = bt; in_ras_type = rt;
        out_ready = rdy; rob_flush = rf; flush_done = fd;
        @(posedge clk);
        model_step(en, rob, fsq, tgt, tk, bt, rt, rdy, rf, fd);
        #1;
    endtask

    task automatic go(input bit en, input logic [5:0] rob, input bit rdy, input bit rf, input bit fd);
        cycle(en, rob, 4'($urandom), $urandom, 1'($urandom), 2'($urandom), 2'($urandom), rdy, rf, fd);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        in_en = 1'b0; in_rob_idx = 6'd0; in_fsq_idx = 4'd0; in_target = 32'd0;
        in_taken = 1'b0; in_br_type = 2'd0; in_ras_type = 2'd0;
        out_ready = 1'b0; rob_flush = 1'b0; flush_done = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0b exp 0", busy); end
        n_checks++; if (redirect_cnt !== 32'd0) begin n_errors++; $display("FAIL reset_cnt got %0h exp 0", redirect_cnt); end
        n_checks++; if ({out_rob_idx, out_fsq_idx, out_target, out_taken, out_br_type, out_ras_type} !== 47'd0) begin
            n_errors++; $display("FAIL reset_payload got rob %0h tgt %0h exp 0", out_rob_idx, out_target); end
    endtask

    task automatic test_idle_capture();
        cycle(1'b1, 6'd7, 4'h3, 32'h8000_0040, 1'b1, 2'd1, 2'd2, 1'b0, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL capture_valid got %0b exp 1", out_valid); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL capture_busy got %0b exp 1", busy); end
        n_checks++; if ({out_rob_idx, out_fsq_idx, out_target, out_taken, out_br_type, out_ras_type} !== {6'd7, 4'h3, 32'h8000_0040, 1'b1, 2'd1, 2'd2}) begin
            n_errors++; $display("FAIL capture_payload got rob %0h tgt %0h exp rob 7 tgt 80000040", out_rob_idx, out_target); end
        for (int i = 0; i < 5; i++) begin
            go(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
            n_checks++; if (out_valid !== 1'b1 || out_rob_idx !== 6'd7) begin
                n_errors++; $display("FAIL capture_hold got v %0b rob %0h exp v 1 rob 7", out_valid, out_rob_idx); end
        end
    endtask

    task automatic test_replace();
        go(1'b1, 6'd3, 1'b0, 1'b0, 1'b0);
        n_checks++; if (out_rob_idx !== 6'd3) begin n_errors++; $display("FAIL replace_older got %0h exp 3", out_rob_idx); end
        go(1'b1, 6'd9, 1'b0, 1'b0, 1'b0);
        n_checks++; if (out_rob_idx !== 6'd3 || out_valid !== 1'b1) begin
            n_errors++; $display("FAIL replace_younger got rob %0h v %0b exp rob 3 v 1", out_rob_idx, out_valid); end
    endtask

    task automatic test_wrap();
        go(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        go(1'b1, 6'h21, 1'b0, 1'b0, 1'b0);
        go(1'b1, 6'd30, 1'b0, 1'b0, 1'b0);
        n_checks++; if (out_rob_idx !== 6'd30) begin n_errors++; $display("FAIL wrap_replace got %0h exp 1e", out_rob_idx); end
        go(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        go(1'b1, 6'd30, 1'b0, 1'b0, 1'b0);
        go(1'b1, 6'h21, 1'b0, 1'b0, 1'b0);
        n_checks++; if (out_rob_idx !== 6'd30) begin n_errors++; $display("FAIL wrap_drop got %0h exp 1e", out_rob_idx); end
    endtask

    task automatic test_fire_squash();
        go(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        go(1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
        go(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b1) begin
            n_errors++; $display("FAIL fire_valid got v %0b busy %0b exp v 0 busy 1", out_valid, busy); end
        n_checks++; if (redirect_cnt !== 32'd1) begin n_errors++; $display("FAIL fire_cnt got %0d exp 1", redirect_cnt); end
        go(1'b1, 6'd8, 1'b0, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL squash_drop got %0b exp 0", out_valid); end
        go(1'b1, 6'd2, 1'b0, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || out_rob_idx !== 6'd2) begin
            n_errors++; $display("FAIL squash_older got v %0b rob %0h exp v 1 rob 2", out_valid, out_rob_idx); end
        go(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        go(1'b1, 6'd8, 1'b0, 1'b0, 1'b1);
        n_checks++; if (out_valid !== 1'b1 || out_rob_idx !== 6'd8 || redirect_cnt !== 32'd2) begin
            n_errors++; $display("FAIL flushdone_accept got v %0b rob %0h cnt %0d exp v 1 rob 8 cnt 2", out_valid, out_rob_idx, redirect_cnt); end
    endtask

    task automatic test_flush_priority();
        go(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        go(1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
        go(1'b1, 6'd1, 1'b0, 1'b1, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || out_rob_idx !== 6'd5) begin
            n_errors++; $display("FAIL flush_prio got v %0b busy %0b rob %0h exp v 0 busy 0 rob 5", out_valid, busy, out_rob_idx); end
        go(1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL flush_drop got %0b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        go(1'b1, 6'd20, 1'b0, 1'b0, 1'b0);
        go(1'b1, 6'd10, 1'b1, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b1 || out_rob_idx !== 6'd10 || redirect_cnt !== 32'd3) begin
            n_errors++; $display("FAIL b2b_fire_load got v %0b rob %0h cnt %0d exp v 1 rob a cnt 3", out_valid, out_rob_idx, redirect_cnt); end
        go(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || redirect_cnt !== 32'd4) begin
            n_errors++; $display("FAIL b2b_fire got v %0b cnt %0d exp v 0 cnt 4", out_valid, redirect_cnt); end
        go(1'b1, 6'd12, 1'b1, 1'b0, 1'b0);
        n_checks++; if (out_valid !== 1'b0 || redirect_cnt !== 32'd4) begin
            n_errors++; $display("FAIL b2b_squash got v %0b cnt %0d exp v 0 cnt 4", out_valid, redirect_cnt); end
    endtask

    task automatic test_saturation();
        go(1'b0, 6'd0, 1'b0, 1'b1, 1'b0);
        #2;
        force dut.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            go(1'b1, 6'd5, 1'b0, 1'b0, 1'b1);
            go(1'b0, 6'd0, 1'b1, 1'b0, 1'b0);
            n_checks++; if (redirect_cnt !== 32'hFFFF_FFFF) begin
                n_errors++; $display("FAIL sat_cnt fire %0d got %0h exp ffffffff", i, redirect_cnt); end
        end
    endtask

    task automatic test_async_reset();
        go(1'b1, 6'd7, 1'b0, 1'b0, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || redirect_cnt !== 32'd0) begin
            n_errors++; $display("FAIL async_rst_ctrl got v %0b busy %0b cnt %0h exp 0", out_valid, busy, redirect_cnt); end
        n_checks++; if ({out_rob_idx, out_fsq_idx, out_target, out_taken, out_br_type, out_ras_type} !== 47'd0) begin
            n_errors++; $display("FAIL async_rst_payload got rob %0h tgt %0h exp 0", out_rob_idx, out_target); end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            go(($urandom % 2) == 0, 6'($urandom), ($urandom % 3) == 0,
               ($urandom % 20) == 0, ($urandom % 8) == 0);
            n_checks++; if (out_valid !== m_pend || busy !== (m_pend || m_wait) || redirect_cnt !== m_cnt) begin
                n_errors++; $display("FAIL rand_ctrl cyc %0d got v %0b busy %0b cnt %0d exp v %0b busy %0b cnt %0d",
                                     i, out_valid, busy, redirect_cnt, m_pend, m_pend || m_wait, m_cnt); end
            n_checks++; if ({out_rob_idx, out_fsq_idx, out_target, out_taken, out_br_type, out_ras_type} !==
                            {m_rob, m_fsq, m_tgt, m_tk, m_bt, m_rt}) begin
                n_errors++; $display("FAIL rand_payload cyc %0d got rob %0h tgt %0h exp rob %0h tgt %0h",
                                     i, out_rob_idx, out_target, m_rob, m_tgt); end
        end
    endtask

    initial begin
        test_reset();
        test_idle_capture();
        test_replace();
        test_wrap();
        test_fire_squash();
        test_flush_priority();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
